// File: rtl/convert_pkg.sv
// Shared constants and format helpers for the fixed-point requantisation pipeline.
// Bit positions are binary exponents: an N-bit value with BIN_PT fraction bits spans [-BIN_PT, N-1-BIN_PT].
package convert_pkg;

  localparam int QUANT_TRUNC     = 0;
  localparam int QUANT_HALF_UP   = 1;
  localparam int QUANT_HALF_EVEN = 2;

  localparam int OVF_WRAP = 0;
  localparam int OVF_SAT  = 1;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int msb_idx(input int n_bits, input int bin_pt);
    return n_bits - 1 - bin_pt;
  endfunction

  function automatic int lsb_idx(input int bin_pt);
    return -bin_pt;
  endfunction

  // Span of both formats plus one guard MSB and one sign bit, so an unsigned
  // input that rounds up past its own MSB still reads as a positive value.
  function automatic int int_width(input int n_in, input int bp_in,
                                   input int n_out, input int bp_out);
    return max_i(msb_idx(n_in, bp_in), msb_idx(n_out, bp_out))
         - min_i(lsb_idx(bp_in), lsb_idx(bp_out)) + 3;
  endfunction

endpackage

// File: rtl/convert_lane.sv
// One channel of the requantiser: stage 1 aligns and rounds, stage 2 range-checks.
// Enables come from the shared handshake in convert_pipe.
module convert_lane
  import convert_pkg::*;
#(
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int SIGNED     = 1,
  parameter int QUANT      = 1,
  parameter int OVERFLOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s1_en,
  input  logic                  s2_en,
  input  logic [N_BITS_IN-1:0]  din,
  output logic [N_BITS_OUT-1:0] dout,
  output logic                  ovf
);

  localparam int LSB_IN  = lsb_idx(BIN_PT_IN);
  localparam int LSB_OUT = lsb_idx(BIN_PT_OUT);
  localparam int LSB_MIN = min_i(LSB_IN, LSB_OUT);
  localparam int IW      = int_width(N_BITS_IN, BIN_PT_IN, N_BITS_OUT, BIN_PT_OUT);
  localparam int PAD     = LSB_IN - LSB_MIN;
  localparam int DROP    = LSB_OUT - LSB_IN;
  // Clamped copy of DROP so shift/index expressions stay legal when nothing is dropped.
  localparam int DP      = (DROP > 0) ? DROP : 1;

  localparam logic signed [IW-1:0] ONE  = IW'(1);
  localparam logic signed [IW-1:0] MAXV = (SIGNED != 0) ? (ONE <<< (N_BITS_OUT - 1)) - ONE
                                                        : (ONE <<< N_BITS_OUT) - ONE;
  localparam logic signed [IW-1:0] MINV = (SIGNED != 0) ? -(ONE <<< (N_BITS_OUT - 1)) : '0;

  function automatic logic signed [IW-1:0] align(input logic [N_BITS_IN-1:0] x);
    logic signed [IW-1:0] e;
    e = {{(IW - N_BITS_IN){(SIGNED != 0) & x[N_BITS_IN-1]}}, x};
    return e <<< PAD;
  endfunction

  // Result is in units of the output LSB.
  function automatic logic signed [IW-1:0] quantise(input logic signed [IW-1:0] x);
    logic signed [IW-1:0] bias;
    bias = '0;
    if (DROP > 0) begin
      if (QUANT == QUANT_HALF_UP) begin
        bias = ONE <<< (DP - 1);
      end else if (QUANT == QUANT_HALF_EVEN) begin
        bias = (ONE <<< (DP - 1)) - ONE + (x[DP] ? ONE : '0);
      end
      return (x + bias) >>> DP;
    end
    return x;
  endfunction

  // Returns {overflow, output bits}.
  function automatic logic [N_BITS_OUT:0] range_fit(input logic signed [IW-1:0] x);
    logic                 hi;
    logic                 lo;
    logic signed [IW-1:0] y;
    hi = (x > MAXV);
    lo = (x < MINV);
    y  = x;
    if (OVERFLOW == OVF_SAT) begin
      if (hi) begin
        y = MAXV;
      end else if (lo) begin
        y = MINV;
      end
    end
    return {hi | lo, N_BITS_OUT'(y)};
  endfunction

  logic signed [IW-1:0]   quant_p1_d;
  logic signed [IW-1:0]   quant_p1_q;
  logic [N_BITS_OUT:0]    fit_p2_d;
  logic [N_BITS_OUT-1:0]  dout_p2_q;
  logic                   ovf_p2_q;

  assign quant_p1_d = quantise(align(din));
  assign fit_p2_d   = range_fit(quant_p1_q);

  // Stage 1: aligned, quantised sample
  always_ff @(posedge clk) begin
    if (s1_en) begin
      quant_p1_q <= quant_p1_d;
    end
  end

  // Stage 2: range-limited output, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p2_q <= '0;
      ovf_p2_q  <= 1'b0;
    end else if (s2_en) begin
      dout_p2_q <= fit_p2_d[N_BITS_OUT-1:0];
      ovf_p2_q  <= fit_p2_d[N_BITS_OUT];
    end
  end

  assign dout = dout_p2_q;
  assign ovf  = ovf_p2_q;

endmodule

// File: rtl/convert_pipe.sv
// Two-stage multi-channel fixed-point format converter with valid/ready backpressure.
// Owns the stage valids, the handshake and the saturating overflow-beat counter.
module convert_pipe
  import convert_pkg::*;
#(
  parameter int N_CHANNELS = 1,
  parameter int N_BITS_IN  = 8,
  parameter int BIN_PT_IN  = 7,
  parameter int N_BITS_OUT = 4,
  parameter int BIN_PT_OUT = 3,
  parameter int SIGNED     = 1,
  parameter int QUANT      = 1,
  parameter int OVERFLOW   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_CHANNELS*N_BITS_IN-1:0]  din,
  input  logic                             din_valid,
  output logic                             din_ready,
  output logic [N_CHANNELS*N_BITS_OUT-1:0] dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [N_CHANNELS-1:0]            dout_ovf,
  output logic [15:0]                      ovf_count
);

  if (QUANT != QUANT_TRUNC && QUANT != QUANT_HALF_UP && QUANT != QUANT_HALF_EVEN) begin : g_bad_quant
    $error("convert_pipe: unsupported QUANT=%0d", QUANT);
  end
  if (OVERFLOW != OVF_WRAP && OVERFLOW != OVF_SAT) begin : g_bad_ovf
    $error("convert_pipe: unsupported OVERFLOW=%0d", OVERFLOW);
  end

  logic        vld_p1_d;
  logic        vld_p1_q;
  logic        vld_p2_d;
  logic        vld_p2_q;
  logic        adv_p2;
  logic        s1_en;
  logic        s2_en;
  logic [15:0] ovf_cnt_d;
  logic [15:0] ovf_cnt_q;

  // Stage 2 moves whenever its slot is empty or the consumer takes the beat,
  // which lets a full pipe accept and emit in the same cycle.
  assign adv_p2    = !vld_p2_q || dout_ready;
  assign din_ready = !vld_p1_q || adv_p2;
  assign s1_en     = din_valid && din_ready;
  assign s2_en     = adv_p2 && vld_p1_q;

  always_comb begin
    vld_p1_d  = din_ready ? din_valid : vld_p1_q;
    vld_p2_d  = adv_p2 ? vld_p1_q : vld_p2_q;
    ovf_cnt_d = ovf_cnt_q;
    if (vld_p2_q && dout_ready && (|dout_ovf) && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // Stage valids and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_lane
    convert_lane #(
      .N_BITS_IN (N_BITS_IN),
      .BIN_PT_IN (BIN_PT_IN),
      .N_BITS_OUT(N_BITS_OUT),
      .BIN_PT_OUT(BIN_PT_OUT),
      .SIGNED    (SIGNED),
      .QUANT     (QUANT),
      .OVERFLOW  (OVERFLOW)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .s1_en(s1_en),
      .s2_en(s2_en),
      .din  (din[c*N_BITS_IN +: N_BITS_IN]),
      .dout (dout[c*N_BITS_OUT +: N_BITS_OUT]),
      .ovf  (dout_ovf[c])
    );
  end

  assign dout_valid = vld_p2_q;
  assign ovf_count  = ovf_cnt_q;

endmodule

// File: tb/tb_convert_pipe.sv
// Scoreboard bench: seven 4-channel converters in lockstep on one random stream,
// each checked against an arithmetic model of its own format pair.
module tb_convert_pipe;

  localparam int NCFG = 7;

  // Config row, MSB first: {OVERFLOW, QUANT, SIGNED, BIN_PT_OUT, N_BITS_OUT, BIN_PT_IN, N_BITS_IN}
  function automatic int P(input int c, input int f);
    logic [6:0][7:0] row;
    case (c)
      0:       row = {8'd1, 8'd1, 8'd1, 8'd3,  8'd4,  8'd7, 8'd8};
      1:       row = {8'd1, 8'd2, 8'd1, 8'd3,  8'd4,  8'd7, 8'd8};
      2:       row = {8'd0, 8'd1, 8'd1, 8'd3,  8'd4,  8'd7, 8'd8};
      3:       row = {8'd1, 8'd0, 8'd1, 8'd3,  8'd4,  8'd7, 8'd8};
      4:       row = {8'd1, 8'd1, 8'd1, 8'd6,  8'd12, 8'd3, 8'd4};
      5:       row = {8'd1, 8'd2, 8'd0, 8'd0,  8'd6,  8'd2, 8'd8};
      default: row = {8'd1, 8'd0, 8'd1, 8'hFE, 8'd4,  8'd7, 8'd8};
    endcase
    return int'($signed(row[f]));
  endfunction

  typedef struct packed {
    logic [NCFG-1:0][47:0] dv;
    logic [NCFG-1:0][3:0]  ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic [15:0] din_d;
  logic        din_valid;
  logic        dout_ready;

  logic [NCFG-1:0]        act_r;
  logic [NCFG-1:0]        act_v;
  logic [NCFG-1:0][3:0]   act_o;
  logic [NCFG-1:0][15:0]  act_cnt;
  logic [NCFG-1:0][47:0]  act_d;
  logic [15:0] dout_0, dout_1, dout_2, dout_3, dout_6;
  logic [47:0] dout_4;
  logic [23:0] dout_5;

  exp_t sb[$];
  int   mcnt[NCFG];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   nout  = 0;

  always #5 clk = ~clk;

  assign din_d = {din[27:24], din[19:16], din[11:8], din[3:0]};
  assign act_d[0] = {32'd0, dout_0};
  assign act_d[1] = {32'd0, dout_1};
  assign act_d[2] = {32'd0, dout_2};
  assign act_d[3] = {32'd0, dout_3};
  assign act_d[4] = dout_4;
  assign act_d[5] = {24'd0, dout_5};
  assign act_d[6] = {32'd0, dout_6};

  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(0,0)), .BIN_PT_IN(P(0,1)), .N_BITS_OUT(P(0,2)),
    .BIN_PT_OUT(P(0,3)), .SIGNED(P(0,4)), .QUANT(P(0,5)), .OVERFLOW(P(0,6))) u_dut0 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[0]),
    .dout(dout_0), .dout_valid(act_v[0]), .dout_ready(dout_ready), .dout_ovf(act_o[0]),
    .ovf_count(act_cnt[0]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(1,0)), .BIN_PT_IN(P(1,1)), .N_BITS_OUT(P(1,2)),
    .BIN_PT_OUT(P(1,3)), .SIGNED(P(1,4)), .QUANT(P(1,5)), .OVERFLOW(P(1,6))) u_dut1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[1]),
    .dout(dout_1), .dout_valid(act_v[1]), .dout_ready(dout_ready), .dout_ovf(act_o[1]),
    .ovf_count(act_cnt[1]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(2,0)), .BIN_PT_IN(P(2,1)), .N_BITS_OUT(P(2,2)),
    .BIN_PT_OUT(P(2,3)), .SIGNED(P(2,4)), .QUANT(P(2,5)), .OVERFLOW(P(2,6))) u_dut2 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[2]),
    .dout(dout_2), .dout_valid(act_v[2]), .dout_ready(dout_ready), .dout_ovf(act_o[2]),
    .ovf_count(act_cnt[2]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(3,0)), .BIN_PT_IN(P(3,1)), .N_BITS_OUT(P(3,2)),
    .BIN_PT_OUT(P(3,3)), .SIGNED(P(3,4)), .QUANT(P(3,5)), .OVERFLOW(P(3,6))) u_dut3 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[3]),
    .dout(dout_3), .dout_valid(act_v[3]), .dout_ready(dout_ready), .dout_ovf(act_o[3]),
    .ovf_count(act_cnt[3]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(4,0)), .BIN_PT_IN(P(4,1)), .N_BITS_OUT(P(4,2)),
    .BIN_PT_OUT(P(4,3)), .SIGNED(P(4,4)), .QUANT(P(4,5)), .OVERFLOW(P(4,6))) u_dut4 (
    .clk(clk), .rst(rst), .din(din_d), .din_valid(din_valid), .din_ready(act_r[4]),
    .dout(dout_4), .dout_valid(act_v[4]), .dout_ready(dout_ready), .dout_ovf(act_o[4]),
    .ovf_count(act_cnt[4]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(5,0)), .BIN_PT_IN(P(5,1)), .N_BITS_OUT(P(5,2)),
    .BIN_PT_OUT(P(5,3)), .SIGNED(P(5,4)), .QUANT(P(5,5)), .OVERFLOW(P(5,6))) u_dut5 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[5]),
    .dout(dout_5), .dout_valid(act_v[5]), .dout_ready(dout_ready), .dout_ovf(act_o[5]),
    .ovf_count(act_cnt[5]));
  convert_pipe #(.N_CHANNELS(4), .N_BITS_IN(P(6,0)), .BIN_PT_IN(P(6,1)), .N_BITS_OUT(P(6,2)),
    .BIN_PT_OUT(P(6,3)), .SIGNED(P(6,4)), .QUANT(P(6,5)), .OVERFLOW(P(6,6))) u_dut6 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(act_r[6]),
    .dout(dout_6), .dout_valid(act_v[6]), .dout_ready(dout_ready), .dout_ovf(act_o[6]),
    .ovf_count(act_cnt[6]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Real-valued requantisation: value = raw * 2^-BIN_PT, rescaled by exact integer division.
  function automatic longint model_ch(input int c, input logic [7:0] raw, output logic ovf);
    int     ni, bpi, no, bpo, sg, qu, sat, k;
    longint v, y, d, q, r, mx, mn;
    ni = P(c,0); bpi = P(c,1); no = P(c,2); bpo = P(c,3);
    sg = P(c,4); qu = P(c,5); sat = P(c,6);
    v = 0;
    for (int b = 0; b < ni; b++) if (raw[b]) v += longint'(1) << b;
    if (sg != 0 && raw[ni-1]) v -= longint'(1) << ni;
    if (bpo >= bpi) begin
      y = v * (longint'(1) << (bpo - bpi));
    end else begin
      k = bpi - bpo;
      d = longint'(1) << k;
      q = v / d;
      if ((v % d) != 0 && v < 0) q = q - 1;
      r = v - q * d;
      y = q;
      if (qu == 1 && r >= d / 2) y = q + 1;
      if (qu == 2 && (r > d / 2 || (r == d / 2 && (q & 1) != 0))) y = q + 1;
    end
    mx  = (sg != 0) ? (longint'(1) << (no - 1)) - 1 : (longint'(1) << no) - 1;
    mn  = (sg != 0) ? -(longint'(1) << (no - 1)) : 0;
    ovf = (y > mx) || (y < mn);
    if (sat != 0 && y > mx) y = mx;
    if (sat != 0 && y < mn) y = mn;
    return y & ((longint'(1) << no) - 1);
  endfunction

  function automatic exp_t expect_word(input logic [31:0] w);
    exp_t   e;
    logic   o;
    longint r;
    e = '0;
    for (int c = 0; c < NCFG; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        r = model_ch(c, w[ch*8 +: 8], o);
        e.dv[c] = e.dv[c] | (48'(r) << (ch * P(c,2)));
        e.ov[c][ch] = o;
      end
    end
    return e;
  endfunction

  // Hand-derived results for the two directed opening beats on configs 0..3.
  function automatic logic [19:0] dir_exp(input int beat, input int c);
    case ({beat[0], c[1:0]})
      3'b000: return {4'b0100, 16'h8711};
      3'b001: return {4'b0100, 16'h8701};
      3'b010: return {4'b0100, 16'h8811};
      3'b011: return {4'b0000, 16'h8701};
      3'b100: return {4'b1000, 16'h7102};
      3'b101: return {4'b1000, 16'h7002};
      3'b110: return {4'b1000, 16'h8102};
      default: return {4'b0000, 16'h70F1};
    endcase
  endfunction

  task automatic drive_beats(input int n, input int rdy_pct, input bit directed);
    logic [31:0] w;
    int          waited;
    for (int i = 0; i < n; i++) begin
      if (directed && i == 0)      w = 32'h807F0810;
      else if (directed && i == 1) w = 32'h7F08F818;
      else                         w = $urandom;
      din = w;
      din_valid = 1'b1;
      waited = 0;
      forever begin
        dout_ready = ($urandom_range(0, 99) < rdy_pct);
        @(negedge clk);
        if (act_r[0]) begin
          sb.push_back(expect_word(w));
          @(posedge clk); #1;
          break;
        end
        @(posedge clk); #1;
        waited++;
        if (waited > 200) begin
          $display("FAIL accept_timeout: got din_ready 0 for %0d cycles, want 1", waited);
          $fatal(1, "input stalled");
        end
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int cyc;
    dout_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk(name, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer.
  initial begin
    exp_t                  e;
    logic                  prev_stall;
    logic [NCFG-1:0][47:0] prev_d;
    logic [NCFG-1:0][3:0]  prev_o;
    logic [19:0]           de;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_o = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        foreach (mcnt[i]) mcnt[i] = 0;
        prev_stall = 1'b0;
        continue;
      end
      chk("lockstep_valid", 64'(act_v), {57'd0, {NCFG{act_v[0]}}});
      chk("lockstep_ready", 64'(act_r), {57'd0, {NCFG{act_r[0]}}});
      if (dout_ready) chk("din_ready_when_draining", 64'(act_r[0]), 64'd1);
      if (prev_stall) begin
        for (int c = 0; c < NCFG; c++) begin
          chk($sformatf("stall_dout_c%0d", c), act_d[c], prev_d[c]);
          chk($sformatf("stall_ovf_c%0d", c), 64'(act_o[c]), 64'(prev_o[c]));
        end
      end
      if (act_v[0] && dout_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          for (int c = 0; c < NCFG; c++) begin
            chk($sformatf("dout_c%0d_beat%0d", c, nout), act_d[c], e.dv[c]);
            chk($sformatf("ovf_c%0d_beat%0d", c, nout), 64'(act_o[c]), 64'(e.ov[c]));
            chk($sformatf("ovf_count_c%0d", c), 64'(act_cnt[c]), 64'(mcnt[c]));
            if (e.ov[c] != 4'd0) mcnt[c]++;
            if (nout < 2 && c < 4) begin
              de = dir_exp(nout, c);
              chk($sformatf("directed_c%0d_beat%0d", c, nout), {12'd0, act_o[c], act_d[c][15:0]}, 64'(de));
            end
          end
          nout++;
        end
      end
      prev_stall = act_v[0] && !dout_ready;
      prev_d = act_d;
      prev_o = act_o;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_dout_valid", 64'(act_v), 64'd0);
    chk("rst_din_ready", 64'(act_r), {57'd0, {NCFG{1'b1}}});
    chk("rst_ovf_count", 64'(act_cnt[0]), 64'd0);
    chk("rst_dout", act_d[0], 64'd0);
    chk("rst_dout_ovf", 64'(act_o[0]), 64'd0);
    @(posedge clk); #1;

    drive_beats(1000, 70, 1'b1);
    drive_beats(40, 100, 1'b0);
    drain("drain_main");

    // Two beats in flight, then reset must discard them.
    dout_ready = 1'b0;
    drive_beats(2, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_dout_valid", 64'(act_v[0]), 64'd0);
    chk("midrst_ovf_count", 64'(act_cnt[0]), 64'd0);
    chk("midrst_din_ready", 64'(act_r[0]), 64'd1);
    @(posedge clk); #1;
    drive_beats(30, 60, 1'b0);
    drain("drain_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
